hazard_control_unit: RTL and testbench

- Pipeline sequencing controller for the 5-stage CPU. It sits beside Forwarding_Unit and covers the hazards that forwarding cannot resolve.
- Load-use hazards: stalls the front end for one cycle and inserts a bubble.
- Control hazards: flushes wrong-path instructions on a taken branch (resolved in EX) and on a jump (decoded in ID).
- Halt: on a halt instruction, drains the pipeline through a small state machine and holds the CPU halted. Also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_control_unit.sv | 130 +++++++++++++
 tb/tb_hazard_control_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, branch/jump flushes, halt drain, stall counter.
// Control outputs are combinational from state and current inputs; state and counters update on CLK.
module hazard_control_unit #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             ID_Halt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteReg,
  input  logic             EX_BranchTaken,
  output logic             PCWre,
  output logic             IF_ID_Wre,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic stall_sat;

  // $0 is hardwired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    load_use = EX_MemRead && (EX_WriteReg != 5'd0) &&
               ((EX_WriteReg == ID_rs) || (ID_UsesRt && (EX_WriteReg == ID_rt)));
  end

  assign stall_sat  = &stall_cnt_q;
  assign StallCount = stall_cnt_q;

  always_comb begin
    PCWre       = 1'b1;
    IF_ID_Wre   = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    Halted      = 1'b0;
    state_d     = state_q;
    drain_d     = drain_q;
    stall_cnt_d = stall_cnt_q;

    if (Reset) begin
      PCWre       = 1'b0;
      IF_ID_Wre   = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      Halted      = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (EX_BranchTaken) begin
            // Everything younger than the branch is wrong-path, including any hazard it raises.
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            PCWre       = 1'b1;
          end else if (load_use) begin
            PCWre       = 1'b0;
            IF_ID_Wre   = 1'b0;
            ID_EX_Flush = 1'b1;
            if (!stall_sat) begin
              stall_cnt_d = stall_cnt_q + 1'b1;
            end
          end else if (ID_Jump) begin
            IF_ID_Flush = 1'b1;
          end else if (ID_Halt) begin
            PCWre       = 1'b0;
            IF_ID_Flush = 1'b1;
            state_d     = ST_DRAIN;
            drain_d     = DRAIN_INIT;
          end
        end

        ST_DRAIN: begin
          PCWre       = 1'b0;
          IF_ID_Wre   = 1'b1;
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
          if (drain_q == 4'd0) begin
            state_d = ST_HALTED;
          end else begin
            drain_d = drain_q - 4'd1;
          end
        end

        ST_HALTED: begin
          PCWre       = 1'b0;
          IF_ID_Wre   = 1'b0;
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
          Halted      = 1'b1;
        end

        default: begin
          state_d = ST_RUN;
          drain_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_RUN;
      drain_q     <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit; a narrow counter keeps the saturation case short.
module tb_hazard_control_unit;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             Reset;
  logic [4:0]       ID_rs, ID_rt, EX_WriteReg;
  logic             ID_UsesRt, ID_Jump, ID_Halt, EX_MemRead, EX_BranchTaken;
  logic             PCWre, IF_ID_Wre, IF_ID_Flush, ID_EX_Flush, Halted;
  logic [CNT_W-1:0] StallCount;

  int checks = 0;
  int errors = 0;

  hazard_control_unit #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .ID_Jump(ID_Jump), .ID_Halt(ID_Halt),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg), .EX_BranchTaken(EX_BranchTaken),
    .PCWre(PCWre), .IF_ID_Wre(IF_ID_Wre), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .Halted(Halted), .StallCount(StallCount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRt = 1'b0; ID_Jump = 1'b0; ID_Halt = 1'b0;
    EX_MemRead = 1'b0; EX_WriteReg = 5'd0; EX_BranchTaken = 1'b0;
  endtask

  // Expected {PCWre, IF_ID_Wre, IF_ID_Flush, ID_EX_Flush, Halted}
  task automatic check_ctl(input string tag, input logic [4:0] exp);
    #1;
    check(tag, 32'({PCWre, IF_ID_Wre, IF_ID_Flush, ID_EX_Flush, Halted}), 32'(exp));
  endtask

  task automatic set_load_use(input logic [4:0] r);
    EX_MemRead = 1'b1; EX_WriteReg = r; ID_rs = r;
  endtask

  initial begin
    Reset = 1'b1;
    clear_inputs();
    #1;
    check_ctl("reset_ctl", 5'b00110);
    tick(); tick();
    check("reset_cnt", 32'(StallCount), 32'd0);
    Reset = 1'b0;
    check_ctl("run_default", 5'b11000);

    set_load_use(5'd5);
    check_ctl("loaduse_rs", 5'b00010);
    tick();
    clear_inputs();
    check("cnt_after_rs", 32'(StallCount), 32'd1);

    EX_MemRead = 1'b1; EX_WriteReg = 5'd5; ID_rs = 5'd1; ID_rt = 5'd5; ID_UsesRt = 1'b0;
    check_ctl("rt_unused", 5'b11000);
    tick();
    ID_UsesRt = 1'b1;
    check_ctl("rt_used", 5'b00010);
    tick();
    clear_inputs();
    check("cnt_after_rt", 32'(StallCount), 32'd2);

    EX_MemRead = 1'b1; EX_WriteReg = 5'd0; ID_rs = 5'd0;
    check_ctl("reg0_no_stall", 5'b11000);
    tick();
    check("cnt_reg0", 32'(StallCount), 32'd2);

    set_load_use(5'd7);
    EX_BranchTaken = 1'b1;
    check_ctl("branch_over_lu", 5'b11110);
    tick();
    clear_inputs();
    check("cnt_branch", 32'(StallCount), 32'd2);

    set_load_use(5'd9);
    ID_Jump = 1'b1;
    check_ctl("jump_waits", 5'b00010);
    tick();
    EX_MemRead = 1'b0;
    check("cnt_jump_stall", 32'(StallCount), 32'd3);
    check_ctl("jump_after", 5'b11100);
    tick();
    clear_inputs();

    // Halt: one accept cycle, three DRAIN cycles, then HALTED.
    ID_Halt = 1'b1;
    check_ctl("halt_accept", 5'b01100);
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      ID_Jump = 1'(i & 1);
      check_ctl($sformatf("drain_%0d", i), 5'b01110);
      tick();
    end
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      EX_BranchTaken = 1'(i & 1);
      EX_MemRead = 1'b1; EX_WriteReg = 5'(i + 1); ID_rs = 5'(i + 1);
      ID_Halt = 1'(~i & 1);
      check_ctl($sformatf("halted_%0d", i), 5'b00111);
      tick();
    end
    clear_inputs();
    check("cnt_halted", 32'(StallCount), 32'd3);

    // Reset mid-drain returns to RUN.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    ID_Halt = 1'b1;
    tick();
    clear_inputs();
    check_ctl("drain_1", 5'b01110);
    tick();
    Reset = 1'b1;
    check_ctl("reset_in_drain", 5'b00110);
    tick();
    Reset = 1'b0;
    check_ctl("run_after_reset", 5'b11000);
    check("cnt_after_reset", 32'(StallCount), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check_ctl("still_running", 5'b11000);

    // Persistent load-use counts every cycle and saturates.
    set_load_use(5'd3);
    for (int i = 0; i < 3; i++) tick();
    check("cnt_persist", 32'(StallCount), 32'd3);
    for (int i = 0; i < 12; i++) tick();
    check("cnt_full", 32'(StallCount), 32'd15);
    check_ctl("stall_at_sat", 5'b00010);
    tick();
    check("cnt_saturated", 32'(StallCount), 32'd15);
    tick();
    clear_inputs();
    check("cnt_saturated2", 32'(StallCount), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
